// File: rtl/app_router_pkg.sv
// Shared definitions for the application router: channel 0 identity, FSM states
// and the per-bus blank fill bits.
package app_router_pkg;

    localparam int unsigned APP_MENU = 0;

    typedef enum logic [1:0] {
        ST_LOCK  = 2'd0,
        ST_MENU  = 2'd1,
        ST_BLANK = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    // Fill bit replicated across each bus while blanked (7-seg is active-low)
    localparam logic BLANK_OLED = 1'b0;
    localparam logic BLANK_LED  = 1'b0;
    localparam logic BLANK_AN   = 1'b1;
    localparam logic BLANK_SEG  = 1'b1;

endpackage

// File: rtl/app_router_chan_mux.sv
// Registered N-way selector on a flattened bus; forces a constant fill while
// blank is high or during reset.
module chan_mux #(
    parameter int unsigned N         = 2,
    parameter int unsigned W         = 8,
    parameter logic        BLANK_BIT = 1'b0,
    localparam int unsigned SW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           blank,
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] data,
    output logic [W-1:0]   out
);

    logic [W-1:0] picked;

    always_comb begin
        picked = {W{BLANK_BIT}};
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(sel) == k) begin
                picked = data[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || blank) begin
            out <= {W{BLANK_BIT}};
        end else begin
            out <= picked;
        end
    end

endmodule

// File: rtl/app_router.sv
// Application switcher: passcode lock, menu/app state machine with a blanking
// window on every switch, one-hot app enables and registered board output mux.
module app_router
    import app_router_pkg::*;
#(
    parameter int unsigned NUM_APPS  = 4,
    parameter int unsigned OLED_W    = 16,
    parameter int unsigned LD_W      = 16,
    parameter int unsigned AN_W      = 4,
    parameter int unsigned SEG_W     = 8,
    parameter int unsigned BLANK_CYC = 4,
    parameter int unsigned IDLE_CYC  = 3000,
    localparam int unsigned SW       = $clog2(NUM_APPS + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         btn_sel,
    input  logic                         pw_ok,
    input  logic [SW-1:0]                menu_sel,
    input  logic [(NUM_APPS+1)*OLED_W-1:0] in_oled,
    input  logic [(NUM_APPS+1)*LD_W-1:0]   in_led,
    input  logic [(NUM_APPS+1)*AN_W-1:0]   in_an,
    input  logic [(NUM_APPS+1)*SEG_W-1:0]  in_seg,
    output logic [OLED_W-1:0]            oled_data,
    output logic [LD_W-1:0]              led,
    output logic [AN_W-1:0]              an,
    output logic [SEG_W-1:0]             seg,
    output logic [NUM_APPS:0]            app_en,
    output logic [SW-1:0]                cur_ch,
    output logic                         locked
);

    localparam int unsigned NCH = NUM_APPS + 1;
    localparam int unsigned BW  = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int unsigned IW  = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_CYC - 1);

    state_t        state, state_n;
    logic [SW-1:0] cur_ch_n;
    logic [SW-1:0] target, target_n;
    logic [BW-1:0] blank_cnt, blank_cnt_n;
    logic [IW-1:0] idle_cnt, idle_cnt_n;
    logic          sel_valid;
    logic          blanking;

    assign sel_valid = (menu_sel != '0) && (32'(menu_sel) <= NUM_APPS);
    assign blanking  = (state == ST_BLANK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_LOCK;
            cur_ch    <= SW'(APP_MENU);
            target    <= SW'(APP_MENU);
            blank_cnt <= '0;
            idle_cnt  <= '0;
        end else begin
            state     <= state_n;
            cur_ch    <= cur_ch_n;
            target    <= target_n;
            blank_cnt <= blank_cnt_n;
            idle_cnt  <= idle_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        cur_ch_n    = cur_ch;
        target_n    = target;
        blank_cnt_n = blank_cnt;
        idle_cnt_n  = idle_cnt;
        case (state)
            ST_LOCK: begin
                if (pw_ok) begin
                    state_n    = ST_MENU;
                    cur_ch_n   = SW'(APP_MENU);
                    idle_cnt_n = '0;
                end
            end
            ST_MENU: begin
                // Any btn_sel counts as activity, even an out-of-range selection
                if (btn_sel) begin
                    idle_cnt_n = '0;
                    if (sel_valid) begin
                        state_n     = ST_BLANK;
                        target_n    = menu_sel;
                        blank_cnt_n = BLANK_LOAD;
                    end
                end else if ((IDLE_CYC != 0) && (idle_cnt == IDLE_LAST)) begin
                    state_n = ST_LOCK;
                end else begin
                    idle_cnt_n = idle_cnt + IW'(1);
                end
            end
            ST_BLANK: begin
                if (blank_cnt == '0) begin
                    if (target != SW'(APP_MENU)) begin
                        state_n  = ST_RUN;
                        cur_ch_n = target;
                    end else begin
                        state_n    = ST_MENU;
                        cur_ch_n   = SW'(APP_MENU);
                        idle_cnt_n = '0;
                    end
                end else begin
                    blank_cnt_n = blank_cnt - BW'(1);
                end
            end
            ST_RUN: begin
                if (btn_sel) begin
                    state_n     = ST_BLANK;
                    target_n    = SW'(APP_MENU);
                    blank_cnt_n = BLANK_LOAD;
                end
            end
            default: state_n = ST_LOCK;
        endcase
    end

    assign app_en = blanking ? '0 : (NCH'(1) << cur_ch);
    assign locked = (state == ST_LOCK);

    chan_mux #(.N(NCH), .W(OLED_W), .BLANK_BIT(BLANK_OLED)) u_mux_oled (
        .clk(clk), .reset(reset), .blank(blanking), .sel(cur_ch), .data(in_oled), .out(oled_data)
    );

    chan_mux #(.N(NCH), .W(LD_W), .BLANK_BIT(BLANK_LED)) u_mux_led (
        .clk(clk), .reset(reset), .blank(blanking), .sel(cur_ch), .data(in_led), .out(led)
    );

    chan_mux #(.N(NCH), .W(AN_W), .BLANK_BIT(BLANK_AN)) u_mux_an (
        .clk(clk), .reset(reset), .blank(blanking), .sel(cur_ch), .data(in_an), .out(an)
    );

    chan_mux #(.N(NCH), .W(SEG_W), .BLANK_BIT(BLANK_SEG)) u_mux_seg (
        .clk(clk), .reset(reset), .blank(blanking), .sel(cur_ch), .data(in_seg), .out(seg)
    );

endmodule
